// File: rtl/weight_fetch_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : weight_fetch_sched_if
// Description : Bundle for the weight fetch scheduler: pass request,
//               status, dual-port BRAM read side and weight output beats.
// Revision    : 1.0 - initial release
// ============================================================================
interface weight_fetch_sched_if #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 33,
    parameter int SPIKE_W = 16,
    parameter int NEURONS = 64
);
    localparam int c_NIDX_W = $clog2(NEURONS);
    localparam int c_PIDX_W = (SPIKE_W > 1) ? $clog2(SPIKE_W) : 1;

    // Pass request
    logic                start;
    logic [SPIKE_W-1:0]  spike_vec;
    logic [ADDR_W-1:0]   base_addr;

    // Status
    logic                busy;
    logic                done;

    // BRAM read side
    logic                bram_en;
    logic [ADDR_W-1:0]   addra;
    logic [ADDR_W-1:0]   addrb;
    logic [DATA_W-1:0]   dout_a;
    logic [DATA_W-1:0]   dout_b;

    // Weight output beats
    logic                wt_valid;
    logic [DATA_W-1:0]   wt_a;
    logic [DATA_W-1:0]   wt_b;
    logic [c_NIDX_W-1:0] nrn_idx;
    logic [c_PIDX_W-1:0] pre_idx;

    // Requester / BRAM model side
    modport master (
        output start, spike_vec, base_addr, dout_a, dout_b,
        input  busy, done, bram_en, addra, addrb,
        input  wt_valid, wt_a, wt_b, nrn_idx, pre_idx
    );

    // Scheduler side
    modport slave (
        input  start, spike_vec, base_addr, dout_a, dout_b,
        output busy, done, bram_en, addra, addrb,
        output wt_valid, wt_a, wt_b, nrn_idx, pre_idx
    );
endinterface
`default_nettype wire

// File: rtl/weight_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module      : weight_fetch_sched
// Description : Walks the set bits of a spike vector (lowest first) and, for
//               each spiking input, streams its NEURONS weights out of a
//               dual-port BRAM two at a time. Read data is re-tagged with the
//               issuing neuron/input index after READ_LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_fetch_sched #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 33,
    parameter int SPIKE_W  = 16,
    parameter int NEURONS  = 64,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    weight_fetch_sched_if.slave bus
);

    localparam int c_NIDX_W = $clog2(NEURONS);
    localparam int c_PIDX_W = (SPIKE_W > 1) ? $clog2(SPIKE_W) : 1;
    localparam int c_ROW_W  = c_PIDX_W + c_NIDX_W;
    localparam int c_SUM_W  = (ADDR_W > c_ROW_W) ? ADDR_W : c_ROW_W;
    localparam int c_CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam int c_J_LAST = NEURONS - 2;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_SCAN  = 3'd1;
    localparam logic [2:0] c_ST_FETCH = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next;

    logic [SPIKE_W-1:0]  r_mask;
    logic [ADDR_W-1:0]   r_base;
    logic [c_NIDX_W-1:0] r_j;
    logic [c_PIDX_W-1:0] r_pre;
    logic [c_CNT_W-1:0]  r_drain;

    logic [READ_LAT-1:0] r_vld_pipe;
    logic [c_NIDX_W-1:0] r_nrn_pipe [READ_LAT];
    logic [c_PIDX_W-1:0] r_pre_pipe [READ_LAT];

    logic [c_PIDX_W-1:0] w_low_idx;
    logic                w_mask_any;
    logic                w_j_last;
    logic                w_drain_last;
    logic                w_busy;
    logic                w_done;
    logic                w_bram_en;
    logic [c_ROW_W-1:0]  w_row;
    logic [c_SUM_W-1:0]  w_sum;
    logic [ADDR_W-1:0]   w_addra;
    logic [ADDR_W-1:0]   w_addrb;
    logic                w_out_vld;

    assign w_mask_any   = |r_mask;
    assign w_j_last     = (r_j == c_NIDX_W'(c_J_LAST));
    assign w_drain_last = (r_drain == c_CNT_W'(READ_LAT - 1));

    // Lowest set bit of the pending mask: scanning downward lets the
    // lowest hit overwrite any higher one.
    always_comb begin
        w_low_idx = '0;
        for (int i = SPIKE_W - 1; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = c_PIDX_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and state-derived status outputs.
    always_comb begin
        w_next    = r_state;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        w_bram_en = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next = c_ST_SCAN;
                end
            end
            c_ST_SCAN: begin
                w_next = w_mask_any ? c_ST_FETCH : c_ST_DRAIN;
            end
            c_ST_FETCH: begin
                w_bram_en = 1'b1;
                if (w_j_last) begin
                    w_next = c_ST_SCAN;
                end
            end
            c_ST_DRAIN: begin
                if (w_drain_last) begin
                    w_next = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_done = 1'b1;
                w_next = c_ST_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = c_ST_IDLE;
            end
        endcase
    end

    // Pass context: mask/base captured only from IDLE, so a start while
    // busy has no effect; the input index and pair counter advance with
    // the scan/fetch walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask  <= '0;
            r_base  <= '0;
            r_j     <= '0;
            r_pre   <= '0;
            r_drain <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_mask <= bus.spike_vec;
                        r_base <= bus.base_addr;
                    end
                end
                c_ST_SCAN: begin
                    r_pre   <= w_low_idx;
                    r_j     <= '0;
                    r_drain <= '0;
                end
                c_ST_FETCH: begin
                    r_j <= r_j + c_NIDX_W'(2);
                    if (w_j_last) begin
                        r_mask[r_pre] <= 1'b0;
                    end
                end
                c_ST_DRAIN: begin
                    r_drain <= r_drain + c_CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Address of the current pair: row pre_idx*NEURONS + j is simply the
    // concatenation {pre, j} since j < NEURONS; the sum wraps at ADDR_W.
    always_comb begin
        w_row   = {r_pre, r_j};
        w_sum   = c_SUM_W'(r_base) + c_SUM_W'(w_row);
        w_addra = w_sum[ADDR_W-1:0];
        w_addrb = w_addra + ADDR_W'(1);
    end

    // Valid/tag delay line matching the BRAM read latency; reset flushes
    // it so reads in flight at reset never surface.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_nrn_pipe[i] <= '0;
                r_pre_pipe[i] <= '0;
            end
        end else begin
            r_vld_pipe[0] <= w_bram_en;
            r_nrn_pipe[0] <= r_j;
            r_pre_pipe[0] <= r_pre;
            for (int i = 1; i < READ_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_nrn_pipe[i] <= r_nrn_pipe[i-1];
                r_pre_pipe[i] <= r_pre_pipe[i-1];
            end
        end
    end

    assign w_out_vld = r_vld_pipe[READ_LAT-1];

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.bram_en  = w_bram_en;
    assign bus.addra    = w_bram_en ? w_addra : '0;
    assign bus.addrb    = w_bram_en ? w_addrb : '0;
    assign bus.wt_valid = w_out_vld;
    assign bus.wt_a     = w_out_vld ? bus.dout_a : '0;
    assign bus.wt_b     = w_out_vld ? bus.dout_b : '0;
    assign bus.nrn_idx  = w_out_vld ? r_nrn_pipe[READ_LAT-1] : '0;
    assign bus.pre_idx  = w_out_vld ? r_pre_pipe[READ_LAT-1] : '0;

endmodule
`default_nettype wire
